// File: rtl/ifid_pkg.sv
// Shared types for the IF/ID skid buffer: occupancy states, NOP word and beat payload.
package ifid_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ifid_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] snpc;
    logic [XLEN-1:0] inst;
  } ifid_beat_t;

endpackage

// File: rtl/if_id_buffer.sv
// Two-entry skid buffer between fetch and decode; flush drops all in-flight beats,
// inst_count tracks beats delivered to decode.
module if_id_buffer
  import ifid_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_snpc,
  input  logic [XLEN-1:0] in_inst,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_snpc,
  output logic [XLEN-1:0] out_inst,
  input  logic            out_ready,
  output logic [XLEN-1:0] inst_count
);

  ifid_state_e     state_q, state_d;
  ifid_beat_t      head_q, head_d;
  ifid_beat_t      skid_q, skid_d;
  logic [XLEN-1:0] inst_count_q, inst_count_d;
  ifid_beat_t      in_beat;
  logic            push, pop;

  assign in_beat = '{pc: in_pc, snpc: in_snpc, inst: in_inst};

  // Handshake flags decode only the state register, never out_ready or flush.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign out_pc     = head_q.pc;
  assign out_snpc   = head_q.snpc;
  assign out_inst   = out_valid ? head_q.inst : NOP_INST;
  assign inst_count = inst_count_q;

  // Next-state, payload steering and delivery counter.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    skid_d       = skid_q;
    inst_count_d = inst_count_q;

    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = in_beat;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_beat;
        end else if (push) begin
          state_d = FULL;
          skid_d  = in_beat;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d = EMPTY;
    end

    if (pop) begin
      inst_count_d = inst_count_q + XLEN'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= EMPTY;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_count_q <= inst_count_d;
    end
  end

  // Payload storage carries no reset; validity comes from the state register.
  always_ff @(posedge clock) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer.
module tb_if_id_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc, in_snpc, in_inst;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc, out_snpc, out_inst;
  logic        out_ready;
  logic [31:0] inst_count;

  int vectors = 0;
  int miscompares = 0;

  if_id_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_snpc    (in_snpc),
    .in_inst    (in_inst),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_snpc   (out_snpc),
    .out_inst   (out_inst),
    .out_ready  (out_ready),
    .inst_count (inst_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_snpc  = pc + 32'd4;
    in_inst  = 32'hA000_0000 | pc;
  endtask

  task automatic chk_empty(input string tag, input logic [31:0] cnt);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_inst"}, out_inst, 32'h0000_0013);
    chk({tag, "_count"}, inst_count, cnt);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic rdy,
                          input logic [31:0] cnt);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, "_count"}, inst_count, cnt);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0);
    step();
    chk_empty("rst", 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_empty("idle", 32'd0);
    end

    // Streaming at full rate
    out_ready = 1'b1;
    drive(1'b1, 32'd0);  step(); chk_head("s0", 32'd0, 1'b1, 32'd0);
    chk("s0_snpc", out_snpc, 32'd4);
    chk("s0_inst", out_inst, 32'hA000_0000);
    drive(1'b1, 32'd4);  step(); chk_head("s4", 32'd4, 1'b1, 32'd1);
    drive(1'b1, 32'd8);  step(); chk_head("s8", 32'd8, 1'b1, 32'd2);
    drive(1'b1, 32'd12); step(); chk_head("s12", 32'd12, 1'b1, 32'd3);
    chk("s12_inst", out_inst, 32'hA000_000C);
    drive(1'b0, 32'd0);  step(); chk_empty("sdone", 32'd4);

    // Decode stall fills the skid
    out_ready = 1'b0;
    drive(1'b1, 32'd0); step(); chk_head("st0", 32'd0, 1'b1, 32'd4);
    drive(1'b1, 32'd4); step(); chk_head("stfull", 32'd0, 1'b0, 32'd4);
    drive(1'b1, 32'd8); step(); chk_head("sthold", 32'd0, 1'b0, 32'd4);
    out_ready = 1'b1;
    drive(1'b0, 32'd0); step(); chk_head("stpop0", 32'd4, 1'b1, 32'd5);
    chk("stpop0_snpc", out_snpc, 32'd8);
    step(); chk_empty("stpop4", 32'd6);

    // Flush while FULL drops everything including the incoming beat
    out_ready = 1'b0;
    drive(1'b1, 32'd0); step();
    drive(1'b1, 32'd4); step(); chk_head("ffull", 32'd0, 1'b0, 32'd6);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'd8); step(); chk_empty("flush", 32'd6);
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h40); step(); chk_head("fnew", 32'h40, 1'b1, 32'd6);
    out_ready = 1'b1;
    drive(1'b0, 32'd0); step(); chk_empty("fdrain", 32'd7);

    // Counter wrap
    @(negedge clock);
    force dut.inst_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.inst_count_q;
    chk("wrap_pre", inst_count, 32'hFFFF_FFFF);
    drive(1'b1, 32'h80); step(); chk_head("wpush", 32'h80, 1'b1, 32'hFFFF_FFFF);
    drive(1'b0, 32'd0);  step(); chk_empty("wrap", 32'd0);

    // Reset from FULL beats concurrent flush and pop
    out_ready = 1'b0;
    drive(1'b1, 32'd0); step();
    drive(1'b1, 32'd4); step();
    out_ready = 1'b1;
    drive(1'b0, 32'd0); step(); chk_head("rf_pop", 32'd4, 1'b1, 32'd1);
    out_ready = 1'b0;
    drive(1'b1, 32'd8); step(); chk_head("rf_full", 32'd4, 1'b0, 32'd1);
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'hC); step(); chk_empty("rf_rst", 32'd0);
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0); step(); chk_empty("rf_after", 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
